vga_digit_renderer: RTL and testbench

- Renders a NUM_DIGITS-digit unsigned decimal number as an on-screen glyph string in the VGA pixel stream.
- Converts a binary value to BCD with a sequential double-dabble engine and commits the new digits only at frame boundaries, so the display never tears.
- Drives the address of the external 8x12 digit font ROM (decimal, row index in; 8-bit row bitmap out, MSB = leftmost pixel) and registers the selected pixel.
- Sits between the VGA timing generator and the pixel colour mux.

---
 rtl/vga_digit_renderer.sv | 183 ++++++++++++++++++
 tb/tb_vga_digit_renderer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_digit_renderer.sv
// Decimal glyph overlay: binary value -> BCD (double dabble), frame-synchronous
// commit of the digits, and a two-stage pixel pipeline driving an external font ROM.
module vga_digit_renderer #(
  parameter int unsigned VALUE_W    = 16,
  parameter int unsigned NUM_DIGITS = 5,
  parameter int unsigned ORIGIN_X   = 64,
  parameter int unsigned ORIGIN_Y   = 48,
  parameter int unsigned SCALE_LOG2 = 1,
  parameter int unsigned LZ_BLANK   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [VALUE_W-1:0] value,
  input  logic               value_valid,
  output logic               value_ready,
  input  logic               frame_start,
  input  logic [9:0]         h_cnt,
  input  logic [9:0]         v_cnt,
  input  logic               de,
  output logic [3:0]         font_digit,
  output logic [3:0]         font_row,
  input  logic [7:0]         font_bitmap,
  output logic               pixel_on,
  output logic               pixel_de
);

  localparam int unsigned BCD_W = 4 * NUM_DIGITS;
  localparam int unsigned CNT_W = $clog2(VALUE_W + 1);
  localparam int unsigned POS_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned BOX_W = (NUM_DIGITS * 8) << SCALE_LOG2;
  localparam int unsigned BOX_H = 12 << SCALE_LOG2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t             state;
  logic [VALUE_W-1:0] bin_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [BCD_W-1:0]   shadow_q;
  logic [BCD_W-1:0]   disp_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [BCD_W-1:0]   bcd_adj_c;
  logic [BCD_W-1:0]   bcd_shift_c;

  logic [10:0]        rx_c;
  logic [10:0]        ry_c;
  logic               inbox_c;
  logic [POS_W-1:0]   pos_c;
  logic [2:0]         col_c;
  logic [3:0]         row_c;
  logic [3:0]         digit_sel_c;
  logic               zero_sel_c;
  logic               blank_c;
  logic [NUM_DIGITS-1:0] zero_from_c;

  logic               inbox_d;
  logic               blank_d;
  logic [2:0]         col_d;
  logic               de_d;

  // Converter is idle whenever it sits in IDLE
  assign value_ready = (state == IDLE);

  // Double-dabble correction: add 3 to every BCD nibble of 5 or more
  always_comb begin
    bcd_adj_c = bcd_q;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj_c[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    bcd_shift_c = (bcd_adj_c << 1) | BCD_W'(bin_q[VALUE_W-1]);
  end

  // Conversion FSM with shadow and frame-synchronous display commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      disp_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (value_valid) begin
            bin_q <= value;
            bcd_q <= '0;
            cnt_q <= '0;
            state <= CONV;
          end
        end
        CONV: begin
          bcd_q <= bcd_shift_c;
          bin_q <= bin_q << 1;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(VALUE_W - 1)) begin
            shadow_q <= bcd_shift_c;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (frame_start) begin
            disp_q <= shadow_q;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Glyph-box relative coordinates, digit slot, font column and row
  always_comb begin
    rx_c    = {1'b0, h_cnt} - 11'(ORIGIN_X);
    ry_c    = {1'b0, v_cnt} - 11'(ORIGIN_Y);
    inbox_c = de & ~rx_c[10] & (rx_c < 11'(BOX_W)) &
              ~ry_c[10] & (ry_c < 11'(BOX_H));
    pos_c   = POS_W'(NUM_DIGITS - 1) - POS_W'(rx_c >> (3 + SCALE_LOG2));
    col_c   = 3'(rx_c >> SCALE_LOG2);
    row_c   = 4'(ry_c >> SCALE_LOG2);
  end

  // Leading-zero mask: zero_from_c[p] is set when digits p..top are all zero
  always_comb begin
    logic acc;
    acc = 1'b1;
    zero_from_c = '0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      acc = acc & (disp_q[4*i +: 4] == 4'd0);
      zero_from_c[i] = acc;
    end
  end

  // Select the displayed digit under the beam and decide leading-zero blanking
  always_comb begin
    digit_sel_c = 4'd0;
    zero_sel_c  = 1'b0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (pos_c == POS_W'(i)) begin
        digit_sel_c = disp_q[4*i +: 4];
        zero_sel_c  = zero_from_c[i];
      end
    end
    blank_c = (LZ_BLANK != 0) & (pos_c != POS_W'(0)) & zero_sel_c;
  end

  // Stage 1: font ROM address and pixel qualifiers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      font_digit <= 4'd0;
      font_row   <= 4'd0;
      inbox_d    <= 1'b0;
      blank_d    <= 1'b0;
      col_d      <= 3'd0;
      de_d       <= 1'b0;
    end else begin
      font_digit <= inbox_c ? digit_sel_c : 4'd0;
      font_row   <= inbox_c ? row_c : 4'd0;
      inbox_d    <= inbox_c;
      blank_d    <= blank_c;
      col_d      <= col_c;
      de_d       <= de;
    end
  end

  // Stage 2: pick the bitmap bit for this column
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_on <= 1'b0;
      pixel_de <= 1'b0;
    end else begin
      pixel_on <= inbox_d & ~blank_d & font_bitmap[3'd7 - col_d];
      pixel_de <= de_d;
    end
  end

endmodule

// File: tb/tb_vga_digit_renderer.sv
// Directed bench for vga_digit_renderer with a small behavioural font ROM.
module tb_vga_digit_renderer;

  logic        clk;
  logic        rst_n;
  logic [15:0] value;
  logic        value_valid;
  logic        value_ready;
  logic        frame_start;
  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic        de;
  logic [3:0]  font_digit;
  logic [3:0]  font_row;
  logic [7:0]  font_bitmap;
  logic        pixel_on;
  logic        pixel_de;

  int checks   = 0;
  int failures = 0;

  vga_digit_renderer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .value       (value),
    .value_valid (value_valid),
    .value_ready (value_ready),
    .frame_start (frame_start),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .de          (de),
    .font_digit  (font_digit),
    .font_row    (font_row),
    .font_bitmap (font_bitmap),
    .pixel_on    (pixel_on),
    .pixel_de    (pixel_de)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Font: rows 0..10 share one bitmap per digit, row 11 is empty
  function automatic logic [7:0] font_fn(input logic [3:0] d, input logic [3:0] r);
    logic [7:0] bm;
    case (d)
      4'd0: bm = 8'h3C;
      4'd1: bm = 8'h18;
      4'd2: bm = 8'h7C;
      4'd3: bm = 8'h7C;
      4'd4: bm = 8'h0C;
      4'd5: bm = 8'hFE;
      4'd6: bm = 8'h7E;
      4'd7: bm = 8'hFE;
      4'd8: bm = 8'h7C;
      4'd9: bm = 8'h7C;
      default: bm = 8'h00;
    endcase
    return (r < 4'd11) ? bm : 8'h00;
  endfunction

  assign font_bitmap = font_fn(font_digit, font_row);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one beam position, return stage-1 digit and stage-2 pixel outputs
  task automatic probe(input int h, input int v, input logic d,
                       output logic [3:0] fd, output logic on, output logic pde);
    h_cnt = 10'(h);
    v_cnt = 10'(v);
    de    = d;
    tick();
    fd = font_digit;
    tick();
    on  = pixel_on;
    pde = pixel_de;
    de  = 1'b0;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] fd;
    logic on, pde;
    rst_n = 1'b0;
    value = '0; value_valid = 1'b0; frame_start = 1'b0;
    h_cnt = '0; v_cnt = '0; de = 1'b0;
    #23;
    checks++; if (value_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got=%b exp=1", value_ready); end
    checks++; if (pixel_on !== 1'b0) begin failures++; $display("FAIL reset_pixel_on: got=%b exp=0", pixel_on); end
    checks++; if (pixel_de !== 1'b0) begin failures++; $display("FAIL reset_pixel_de: got=%b exp=0", pixel_de); end
    checks++; if (font_digit !== 4'd0) begin failures++; $display("FAIL reset_font_digit: got=%0d exp=0", font_digit); end
    tick();
    rst_n = 1'b1;
    tick();
    probe(132, 48, 1'b1, fd, on, pde);
    checks++; if (on !== 1'b1) begin failures++; $display("FAIL reset_units_zero_lit: got=%b exp=1", on); end
    checks++; if (pde !== 1'b1) begin failures++; $display("FAIL reset_pixel_de_follow: got=%b exp=1", pde); end
    probe(68, 48, 1'b1, fd, on, pde);
    checks++; if (on !== 1'b0) begin failures++; $display("FAIL reset_leading_blank: got=%b exp=0", on); end
  endtask

  task automatic test_conv_1234();
    logic [3:0] fd;
    logic on, pde;
    value = 16'd1234; value_valid = 1'b1;
    checks++; if (value_ready !== 1'b1) begin failures++; $display("FAIL c1234_ready_before: got=%b exp=1", value_ready); end
    tick();
    value_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      checks++; if (value_ready !== 1'b0) begin failures++; $display("FAIL c1234_ready_busy cyc%0d: got=%b exp=0", i, value_ready); end
      tick();
    end
    pulse_frame();
    checks++; if (value_ready !== 1'b1) begin failures++; $display("FAIL c1234_ready_after_commit: got=%b exp=1", value_ready); end
    probe(86, 48, 1'b1, fd, on, pde);
    checks++; if (fd !== 4'd1) begin failures++; $display("FAIL c1234_digit_pos3: got=%0d exp=1", fd); end
    checks++; if (on !== 1'b1) begin failures++; $display("FAIL c1234_h86: got=%b exp=1", on); end
    probe(80, 48, 1'b1, fd, on, pde);
    checks++; if (on !== 1'b0) begin failures++; $display("FAIL c1234_h80: got=%b exp=0", on); end
    probe(64, 48, 1'b1, fd, on, pde);
    checks++; if (on !== 1'b0) begin failures++; $display("FAIL c1234_h64_blank: got=%b exp=0", on); end
    probe(63, 48, 1'b1, fd, on, pde);
    checks++; if (on !== 1'b0) begin failures++; $display("FAIL c1234_h63_outside: got=%b exp=0", on); end
    checks++; if (fd !== 4'd0) begin failures++; $display("FAIL c1234_h63_digit: got=%0d exp=0", fd); end
    probe(136, 48, 1'b1, fd, on, pde);
    checks++; if (fd !== 4'd4) begin failures++; $display("FAIL c1234_digit_pos0: got=%0d exp=4", fd); end
    checks++; if (on !== 1'b1) begin failures++; $display("FAIL c1234_h136: got=%b exp=1", on); end
    probe(104, 48, 1'b1, fd, on, pde);
    checks++; if (fd !== 4'd2) begin failures++; $display("FAIL c1234_digit_pos2: got=%0d exp=2", fd); end
    probe(86, 48, 1'b0, fd, on, pde);
    checks++; if (on !== 1'b0) begin failures++; $display("FAIL c1234_de_low_on: got=%b exp=0", on); end
    checks++; if (pde !== 1'b0) begin failures++; $display("FAIL c1234_de_low_pde: got=%b exp=0", pde); end
    probe(86, 71, 1'b1, fd, on, pde);
    checks++; if (on !== 1'b0) begin failures++; $display("FAIL c1234_row11: got=%b exp=0", on); end
    probe(86, 72, 1'b1, fd, on, pde);
    checks++; if (fd !== 4'd0) begin failures++; $display("FAIL c1234_below_box_digit: got=%0d exp=0", fd); end
  endtask

  task automatic test_max_value();
    logic [3:0] fd;
    logic on, pde;
    logic exp_on;
    value = 16'd65535; value_valid = 1'b1;
    tick();
    value_valid = 1'b0;
    repeat (18) tick();
    pulse_frame();
    probe(70, 48, 1'b1, fd, on, pde);
    checks++; if (fd !== 4'd6) begin failures++; $display("FAIL max_digit_pos4: got=%0d exp=6", fd); end
    probe(120, 48, 1'b1, fd, on, pde);
    checks++; if (fd !== 4'd3) begin failures++; $display("FAIL max_digit_pos1: got=%0d exp=3", fd); end
    for (int k = 0; k < 16; k++) begin
      exp_on = (k >= 2) && (k < 14);
      probe(64 + k, 48, 1'b1, fd, on, pde);
      checks++; if (on !== exp_on) begin failures++; $display("FAIL max_six_row0 h=%0d: got=%b exp=%b", 64 + k, on, exp_on); end
    end
  endtask

  task automatic test_commit_timing();
    logic [3:0] fd;
    logic on, pde;
    value = 16'd42; value_valid = 1'b1;
    tick();
    value_valid = 1'b0;
    repeat (4) tick();
    pulse_frame();
    checks++; if (value_ready !== 1'b0) begin failures++; $display("FAIL ct_conv_frame_ignored: got=%b exp=0", value_ready); end
    repeat (10) tick();
    pulse_frame();
    checks++; if (value_ready !== 1'b0) begin failures++; $display("FAIL ct_hold_entry_frame_ignored: got=%b exp=0", value_ready); end
    value = 16'd7; value_valid = 1'b1;
    tick();
    checks++; if (value_ready !== 1'b0) begin failures++; $display("FAIL ct_hold_not_ready: got=%b exp=0", value_ready); end
    probe(70, 48, 1'b1, fd, on, pde);
    checks++; if (fd !== 4'd6) begin failures++; $display("FAIL ct_display_unchanged: got=%0d exp=6", fd); end
    pulse_frame();
    checks++; if (value_ready !== 1'b1) begin failures++; $display("FAIL ct_commit_ready: got=%b exp=1", value_ready); end
    tick();
    value_valid = 1'b0;
    checks++; if (value_ready !== 1'b0) begin failures++; $display("FAIL ct_second_accepted: got=%b exp=0", value_ready); end
    probe(112, 48, 1'b1, fd, on, pde);
    checks++; if (fd !== 4'd4) begin failures++; $display("FAIL ct_42_tens: got=%0d exp=4", fd); end
    probe(100, 48, 1'b1, fd, on, pde);
    checks++; if (on !== 1'b0) begin failures++; $display("FAIL ct_42_blank_pos2: got=%b exp=0", on); end
    repeat (20) tick();
    pulse_frame();
    checks++; if (value_ready !== 1'b1) begin failures++; $display("FAIL ct_7_commit_ready: got=%b exp=1", value_ready); end
    probe(128, 48, 1'b1, fd, on, pde);
    checks++; if (fd !== 4'd7) begin failures++; $display("FAIL ct_7_digit: got=%0d exp=7", fd); end
    checks++; if (on !== 1'b1) begin failures++; $display("FAIL ct_7_pixel: got=%b exp=1", on); end
    probe(116, 48, 1'b1, fd, on, pde);
    checks++; if (on !== 1'b0) begin failures++; $display("FAIL ct_7_blank_pos1: got=%b exp=0", on); end
  endtask

  task automatic test_reset_mid_conv();
    logic [3:0] fd;
    logic on, pde;
    value = 16'd999; value_valid = 1'b1;
    tick();
    value_valid = 1'b0;
    repeat (8) tick();
    checks++; if (value_ready !== 1'b0) begin failures++; $display("FAIL rm_busy_before_reset: got=%b exp=0", value_ready); end
    rst_n = 1'b0;
    #1;
    checks++; if (value_ready !== 1'b1) begin failures++; $display("FAIL rm_ready_async: got=%b exp=1", value_ready); end
    tick();
    rst_n = 1'b1;
    tick();
    pulse_frame();
    checks++; if (value_ready !== 1'b1) begin failures++; $display("FAIL rm_no_commit: got=%b exp=1", value_ready); end
    probe(128, 48, 1'b1, fd, on, pde);
    checks++; if (fd !== 4'd0) begin failures++; $display("FAIL rm_units_digit: got=%0d exp=0", fd); end
    checks++; if (on !== 1'b0) begin failures++; $display("FAIL rm_zero_col0: got=%b exp=0", on); end
    probe(132, 48, 1'b1, fd, on, pde);
    checks++; if (on !== 1'b1) begin failures++; $display("FAIL rm_zero_col2: got=%b exp=1", on); end
    probe(100, 48, 1'b1, fd, on, pde);
    checks++; if (on !== 1'b0) begin failures++; $display("FAIL rm_blank_pos2: got=%b exp=0", on); end
  endtask

  initial begin
    test_reset();
    test_conv_1234();
    test_max_value();
    test_commit_timing();
    test_reset_mid_conv();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
